booth_r4_mul: RTL and testbench

BOOTH_R4_MUL -- requirements
Module: booth_r4_mul

---
 rtl/booth_r4_mul.sv | 119 +++++++++++
 tb/tb_booth_r4_mul.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mul.sv
// Radix-4 Booth sequential multiplier, signed or unsigned operands, 2*WIDTH-bit product.
// Latency: start accepted at an edge -> WIDTH/2+1 CALC cycles -> one-cycle DONE pulse.
// Backpressure: start is ignored while busy; product holds until the next result is written.
module booth_r4_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int N  = WIDTH / 2 + 1;   // number of Booth iterations
  localparam int EW = WIDTH + 2;       // extended operand width
  localparam int AW = WIDTH + 4;       // accumulator width, holds +/-2A without loss
  localparam int CW = $clog2(N);
  localparam int FW = AW + EW;         // concatenated accumulator/multiplier width

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        a_ext_q;       // extended multiplicand
  logic [EW-1:0]        b_q;           // multiplier, shifted out as product low bits arrive
  logic                 bm1_q;         // bit below the current triplet
  logic [AW-1:0]        acc_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 accept;

  logic [2:0]           triplet;
  logic [AW-1:0]        a_sx, a_x2, pp, sum;
  logic [FW-1:0]        shifted;
  logic                 last_iter;

  assign last_iter = (cnt_q == CW'(N - 1));

  // FSM next state and control outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Booth recoding of the current triplet and one add-then-shift step
  always_comb begin
    triplet = {b_q[1], b_q[0], bm1_q};
    a_sx    = {{2{a_ext_q[EW-1]}}, a_ext_q};
    a_x2    = a_sx << 1;
    pp      = '0;
    case (triplet)
      3'b001, 3'b010: pp = a_sx;
      3'b011:         pp = a_x2;
      3'b100:         pp = ~a_x2 + AW'(1);
      3'b101, 3'b110: pp = ~a_sx + AW'(1);
      default:        pp = '0;
    endcase
    sum     = acc_q + pp;
    shifted = {{2{sum[AW-1]}}, sum, b_q[EW-1:2]};
  end

  // State register and datapath; operands are loaded only on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_ext_q   <= '0;
      b_q       <= '0;
      bm1_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_ext_q <= {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
        b_q     <= {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
        bm1_q   <= 1'b0;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == CALC) begin
        acc_q <= shifted[FW-1:EW];
        b_q   <= shifted[EW-1:0];
        bm1_q <= b_q[1];
        cnt_q <= cnt_q + CW'(1);
        if (last_iter) product_q <= shifted[2*WIDTH-1:0];
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
module tb_booth_r4_mul;

  localparam int WIDTH = 16;

  logic               clk;
  logic               rst;
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  booth_r4_mul #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total  = 0;
  int passed = 0;
  int done_total = 0;
  int t0 = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every done pulse pops one expected product
  always @(negedge clk) begin
    if (!rst && done) begin
      done_total++;
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done with product %0h, expected no done", product);
      end else begin
        check("product", {32'h0, product}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic start_op(input logic sm, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input bit push);
    @(posedge clk);
    #1;
    start        = 1'b1;
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    t0           = cyc;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded) and checks latency and, optionally, the busy length
  task automatic wait_done(input string name, input bit chk_busy);
    int nb;
    bit ok;
    nb = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
      if (busy) nb++;
    end
    if (!ok) begin
      total++;
      $display("FAIL %s_timeout: got no done within 30 cycles, expected done", name);
    end else begin
      check({name, "_latency"}, 64'(cyc - t0), 64'd10);
      if (chk_busy) check({name, "_busy_cycles"}, 64'(nb), 64'd9);
    end
  endtask

  initial begin
    int d0;
    int c1;
    rst          = 1'b1;
    start        = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'd0);
    check("reset_done", {63'h0, done}, 64'd0);
    check("reset_product", {32'h0, product}, 64'd0);

    // Directed vectors
    start_op(1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b1);
    wait_done("s_m1xm1", 1'b1);
    start_op(1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b1);
    wait_done("s_minxmin", 1'b1);
    start_op(1'b1, 16'h7FFF, 16'h8000, 32'hC0008000, 1'b1);
    wait_done("s_maxxmin", 1'b0);
    start_op(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    wait_done("u_onesxones", 1'b1);
    start_op(1'b1, 16'h0003, 16'hFFFE, 32'hFFFFFFFA, 1'b1);
    wait_done("s_3xm2", 1'b0);
    start_op(1'b0, 16'h1234, 16'h5678, 32'h06260060, 1'b1);
    wait_done("u_1234x5678", 1'b0);
    start_op(1'b0, 16'h0000, 16'h1234, 32'h00000000, 1'b1);
    wait_done("u_zero", 1'b1);

    // Start pulsed mid-CALC with other operands must be ignored
    start_op(1'b1, 16'h0005, 16'hFFFD, 32'hFFFFFFF1, 1'b1);
    d0 = done_total;
    repeat (3) @(posedge clk);
    #1;
    check("product_held_in_calc", {32'h0, product}, 64'h0);
    start        = 1'b1;
    signed_mode  = 1'b0;
    multiplicand = 16'h1111;
    multiplier   = 16'h2222;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("mid_start", 1'b0);
    repeat (15) @(negedge clk);
    check("mid_start_single_done", 64'(done_total - d0), 64'd1);

    // Back-to-back: start held high through DONE
    @(posedge clk);
    #1;
    start        = 1'b1;
    signed_mode  = 1'b1;
    multiplicand = 16'h0002;
    multiplier   = 16'h0003;
    exp_q.push_back(32'h00000006);
    c1 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        c1 = cyc;
        break;
      end
    end
    multiplicand = 16'hFFF9;
    multiplier   = 16'h0004;
    exp_q.push_back(32'hFFFFFFE4);
    @(posedge clk);
    #1 start = 1'b0;
    t0 = c1;
    wait_done("b2b_spacing", 1'b1);

    // Reset during CALC cycle 4 aborts with no done
    start_op(1'b1, 16'h1234, 16'h0002, 32'h0, 1'b0);
    d0 = done_total;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'h0, busy}, 64'd0);
    check("abort_product", {32'h0, product}, 64'd0);
    repeat (15) @(negedge clk);
    check("abort_no_done", 64'(done_total - d0), 64'd0);
    start_op(1'b1, 16'hFF00, 16'h0100, 32'hFFFF0000, 1'b1);
    wait_done("after_abort", 1'b1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
